// File: rtl/data_mem_sequencer_if.sv
// Word-wide data bus between the memory-stage sequencer and external data memory.
// The master side issues registered request fields; the slave answers with
// bus_ack and the read word.
interface data_mem_sequencer_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/data_mem_sequencer.sv
// data_mem_sequencer: turns each load/store of the single-cycle core's memory
// stage into one request/acknowledge transaction on a word-wide data bus,
// holding the core (stall) until it completes. Does byte-lane steering,
// alignment checking and load sign/zero extension.
// Optional feature macro: MEM_TIMEOUT_EN -- when defined, a REQ that sees no
// bus_ack for TIMEOUT_CYCLES cycles is aborted and bus_error pulses for the
// DONE cycle. When undefined, REQ waits indefinitely and bus_error is 0.
module data_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemWrite,
  input  logic                 MemToReg,
  input  logic [1:0]           MEM_size,
  input  logic                 unsigned_ALU_op,
  input  logic [31:0]          ALU_result,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 stall,
  output logic                 addr_error,
  output logic                 bus_error,
  data_mem_sequencer_if.master bus
);

  // Reject parameter sets where the timeout could never be reached.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_timeout
    $error("data_mem_sequencer: TIMEOUT_CYCLES out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;

  logic        op;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_ext;
  logic        timeout_hit;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      2'b00: begin
        case (lo)
          2'b00:   be = 4'b0001;
          2'b01:   be = 4'b0010;
          2'b10:   be = 4'b0100;
          default: be = 4'b1000;
        endcase
      end
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Copy the store data into every lane it could land in, so the enables alone pick the target.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      2'b00:   r = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   r = {wd[15:0], wd[15:0]};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of the read word and widen it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                              input logic [1:0] lo, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Decode the incoming request and precompute its bus fields.
  always_comb begin
    op         = MemWrite | MemToReg;
    misaligned = (MEM_size == 2'b11) ||
                 ((MEM_size == 2'b01) && ALU_result[0]) ||
                 ((MEM_size == 2'b10) && (ALU_result[1:0] != 2'b00));
    be_calc    = lane_enables(MEM_size, ALU_result[1:0]);
    wdata_calc = replicate(MEM_size, write_data);
    load_ext   = extend_load(size_q, unsigned_q, lane_q, bus.bus_rdata);
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;

  // Count REQ cycles without ack; the abort fires on the edge the count reaches the limit.
  always_comb begin
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      REQ: begin
        if (!bus.bus_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TIMEOUT_LIMIT) begin
            timeout_hit = 1'b1;
          end
        end
      end
      DONE:    cnt_d = '0;
      default: cnt_d = cnt_q;
    endcase
    bus_error_d = timeout_hit;
  end

  // Wait counter and the error flag that covers exactly the aborted DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // Sequencer next-state logic: launch, wait for ack (or abort), then one retire cycle.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    read_data_d = read_data_q;
    lane_d      = lane_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    stall       = 1'b0;
    addr_error  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          if (misaligned) begin
            addr_error = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = MemWrite;
            bus_addr_d  = {ALU_result[31:2], 2'b00};
            bus_be_d    = be_calc;
            bus_wdata_d = wdata_calc;
            lane_d      = ALU_result[1:0];
            size_d      = MEM_size;
            unsigned_d  = unsigned_ALU_op;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
          if (!bus_we_q) begin
            read_data_d = load_ext;
          end
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered bus fields; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      read_data_q <= 32'h0;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      read_data_q <= read_data_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign read_data     = read_data_q;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Testbench for data_mem_sequencer: drives loads/stores, acts as the bus slave
// with a configurable ack delay and checks results against a queue of
// expected transactions. Build with MEM_TIMEOUT_EN to exercise the abort path.
module tb_data_mem_sequencer;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_CYCLES = 4;
`else
  localparam int TO_CYCLES = 16;
`endif

  typedef struct {
    logic        mis;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        timeout;
    int          stall_cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic        mem_to_reg;
  logic [1:0]  mem_size;
  logic        uns_op;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        addr_error;
  logic        bus_error;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_read;
  exp_t        sb[$];

  data_mem_sequencer_if bus_if ();

  data_mem_sequencer #(
    .TIMEOUT_CYCLES(TO_CYCLES),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MemWrite(mem_write),
    .MemToReg(mem_to_reg),
    .MEM_size(mem_size),
    .unsigned_ALU_op(uns_op),
    .ALU_result(alu_result),
    .write_data(write_data),
    .read_data(read_data),
    .stall(stall),
    .addr_error(addr_error),
    .bus_error(bus_error),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] lo, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {lo, 3'b000};
    case (size)
      2'b00:   return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  // One memory-stage instruction; waits < 0 means the slave never acks.
  task automatic applyStimulus(input logic we, input logic ld, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rd, input int waits);
    exp_t e;
    exp_t got;
    int   stall_cnt;
    int   req_cnt;
    bit   done;
    bit   popped;
    e.mis   = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    e.we    = we;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = model_be(size, addr[1:0]);
    e.wdata = model_wdata(size, wd);
`ifdef MEM_TIMEOUT_EN
    e.timeout = (waits < 0);
`else
    e.timeout = 1'b0;
`endif
    e.rd           = (e.mis || we || e.timeout) ? last_read : model_load(size, uns, addr[1:0], rd);
    e.stall_cycles = e.timeout ? TO_CYCLES + 1 : waits + 2;
    sb.push_back(e);

    @(posedge clk);
    #1;
    mem_write        = we;
    mem_to_reg       = ld;
    mem_size         = size;
    uns_op           = uns;
    alu_result       = addr;
    write_data       = wd;
    bus_if.bus_rdata = rd;

    if (e.mis) begin
      @(negedge clk);
      got = sb.pop_front();
      checkOutput("mis_addr_error", {31'b0, addr_error}, 32'd1);
      checkOutput("mis_stall", {31'b0, stall}, 32'd0);
      checkOutput("mis_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
      @(posedge clk);
      #1;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      @(negedge clk);
      checkOutput("mis_addr_error_drop", {31'b0, addr_error}, 32'd0);
      checkOutput("mis_bus_req_after", {31'b0, bus_if.bus_req}, 32'd0);
      checkOutput("mis_read_data", read_data, got.rd);
    end else begin
      stall_cnt = 0;
      req_cnt   = 0;
      done      = 1'b0;
      popped    = 1'b0;
      got       = e;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        @(negedge clk);
        if (cyc == 0) checkOutput("addr_error_quiet", {31'b0, addr_error}, 32'd0);
        if (stall) stall_cnt++;
        else if (stall_cnt > 0) done = 1'b1;
        if (bus_if.bus_req) begin
          req_cnt++;
          if (!popped) begin
            got    = sb.pop_front();
            popped = 1'b1;
          end
          checkOutput("bus_we", {31'b0, bus_if.bus_we}, {31'b0, got.we});
          checkOutput("bus_addr", bus_if.bus_addr, got.addr);
          checkOutput("bus_be", {28'b0, bus_if.bus_be}, {28'b0, got.be});
          checkOutput("bus_wdata", bus_if.bus_wdata, got.wdata);
        end
        if (done) begin
          if (!popped) begin
            checkOutput("bus_req_seen", 32'd0, 32'd1);
            got    = sb.pop_front();
            popped = 1'b1;
          end
          checkOutput("stall_cycles", stall_cnt, got.stall_cycles);
          checkOutput("read_data", read_data, got.rd);
          checkOutput("bus_error", {31'b0, bus_error}, {31'b0, got.timeout});
          checkOutput("done_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
        end
        bus_if.bus_ack = (waits >= 0) && bus_if.bus_req && (req_cnt == waits + 1);
      end
      if (!done) begin
        checkOutput("done_bound", 32'd0, 32'd1);
        if (!popped && sb.size() > 0) got = sb.pop_front();
      end
      bus_if.bus_ack = 1'b0;
      @(posedge clk);
      #1;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      @(negedge clk);
      checkOutput("idle_bus_error", {31'b0, bus_error}, 32'd0);
    end
    last_read = got.rd;
  endtask

  // Overall runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=0 exp=1");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst              = 1'b1;
    mem_write        = 1'b0;
    mem_to_reg       = 1'b0;
    mem_size         = 2'b10;
    uns_op           = 1'b0;
    alu_result       = 32'h0;
    write_data       = 32'h0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    last_read        = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
    checkOutput("rst_bus_addr", bus_if.bus_addr, 32'h0);
    checkOutput("rst_bus_be", {28'b0, bus_if.bus_be}, 32'h0);
    checkOutput("rst_read_data", read_data, 32'h0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    //              we    ld    size   uns   addr          wd            rdata         waits
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        32'h80FF_1234, 0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        32'h80FF_1234, 1);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0,        32'hBEEF_0000, 0);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_CAFE, 32'h0,        0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'h1111_2222, 0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        32'h1111_2222, 0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        32'h1234_5678, 5);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h1234_56A5, 32'h0,        0);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_CAFE, 32'h0,        2);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0002, 32'h0,        32'hBEEF_0000, 0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_7F00, 3);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'h1122_3344, 32'h5555_5555, 1);
`ifdef MEM_TIMEOUT_EN
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h0,        32'hAAAA_BBBB, -1);
`else
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h0,        32'hAAAA_BBBB, 20);
`endif

    // Reset in the second REQ cycle of a load.
    @(posedge clk);
    #1;
    mem_to_reg       = 1'b1;
    mem_size         = 2'b10;
    alu_result       = 32'h0000_0044;
    bus_if.bus_rdata = 32'h9999_0000;
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_bus_req", {31'b0, bus_if.bus_req}, 32'd1);
    rst        = 1'b1;
    mem_to_reg = 1'b0;
    #1;
    checkOutput("mid_rst_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
    checkOutput("mid_rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("mid_rst_bus_addr", bus_if.bus_addr, 32'h0);
    checkOutput("mid_rst_bus_we", {31'b0, bus_if.bus_we}, 32'd0);
    checkOutput("mid_rst_bus_be", {28'b0, bus_if.bus_be}, 32'h0);
    checkOutput("mid_rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    checkOutput("mid_rst_read_data", read_data, 32'h0);
    checkOutput("mid_rst_errors", {30'b0, addr_error, bus_error}, 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    last_read = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
    checkOutput("post_rst_stall", {31'b0, stall}, 32'd0);

    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0001, 32'h0, 32'h0000_C300, 0);
    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
